dmem_responder: RTL

- Data-memory end of the load/store interface.
- Accepts one load address per cycle and returns the data at a fixed read latency matched to the load/store unit's LOAD_WAIT slotting.
- Accepts one committed store per cycle from the store buffer drain.
- Sits between the load/store unit and the memory array; replaces ad-hoc testbench memories.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_delay_line.sv | 54 +++++
 rtl/dmem_responder.sv | 74 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and response record for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W               = 16;
  localparam int unsigned ADDR_W               = 16;
  localparam int unsigned DEFAULT_READ_LATENCY = 2;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_delay_line.sv
// Read-response pipeline: DEPTH stages of dmem_rsp_t with async reset and a
// synchronous flush that drops every in-flight valid bit.
module dmem_delay_line
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_READ_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data
);

  localparam int unsigned Last = DEPTH - 1;

  dmem_rsp_t r_stage [DEPTH];
  dmem_rsp_t w_src   [DEPTH];
  dmem_rsp_t w_next  [DEPTH];

  always_comb begin
    w_src[0] = {i_valid, i_data};
    for (int i = 1; i < DEPTH; i++) begin
      w_src[i] = r_stage[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i].valid = w_src[i].valid & ~i_flush;
      w_next[i].data  = w_src[i].data;
    end
    // Output stage keeps the last delivered word across bubbles and flushes.
    if (!w_next[Last].valid) begin
      w_next[Last].data = r_stage[Last].data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage <= w_next;
    end
  end

  assign o_valid = r_stage[Last].valid;
  assign o_data  = r_stage[Last].data;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory end of the load/store interface: pipelined loads, one store per cycle.
// Define DMEM_BYPASS_EN for write-first same-index collisions (default read-first).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BITS   = 10,
  parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_mem_location,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_commit_location,
  input  logic [WORD_W-1:0] i_commit_data,
  input  logic              i_commit_valid,
  output logic [WORD_W-1:0] o_mem_data,
  output logic              o_mem_rsp_valid,
  output logic [15:0]       o_write_count
);

  localparam int unsigned Depth = 1 << DEPTH_BITS;

  logic [WORD_W-1:0]     r_mem [Depth];
  logic [15:0]           r_write_count;
  logic [DEPTH_BITS-1:0] w_rd_idx;
  logic [DEPTH_BITS-1:0] w_wr_idx;
  logic [WORD_W-1:0]     w_rd_word;
  logic                  w_wr_en;
  logic                  w_unused_addr;

  // Upper address bits alias onto the array.
  assign w_rd_idx      = i_mem_location[DEPTH_BITS-1:0];
  assign w_wr_idx      = i_commit_location[DEPTH_BITS-1:0];
  assign w_unused_addr = ^{i_mem_location[ADDR_W-1:DEPTH_BITS],
                           i_commit_location[ADDR_W-1:DEPTH_BITS]};
  assign w_wr_en       = i_commit_valid & ~i_reset;

  // Array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_commit_data;
    end
  end

`ifdef DMEM_BYPASS_EN
  assign w_rd_word = (w_wr_en && (w_wr_idx == w_rd_idx)) ? i_commit_data : r_mem[w_rd_idx];
`else
  assign w_rd_word = r_mem[w_rd_idx];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_write_count <= '0;
    end else if (i_commit_valid) begin
      r_write_count <= r_write_count + 16'd1;
    end
  end

  dmem_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_delay_line (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_valid (i_mem_valid),
    .i_data  (w_rd_word),
    .o_valid (o_mem_rsp_valid),
    .o_data  (o_mem_data)
  );

  assign o_write_count = r_write_count;

endmodule
